// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the trace-line tools that sit on the cpu_checker char bus:
// format codes, field-capture FSM states and character classification helpers.
package cpu_trace_pkg;

  // cpu_checker verdicts on a completed line
  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_REG  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  // Field-capture FSM states (4-bit encoding)
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_TIME = 4'd1,
    S_PC   = 4'd2,
    S_GAP  = 4'd3,
    S_REG  = 4'd4,
    S_ADDR = 4'd5,
    S_ARW  = 4'd6,
    S_DATA = 4'd7
  } state_e;

  // Line delimiters and separators
  localparam logic [7:0] CH_CARET = 8'h5E; // '^'
  localparam logic [7:0] CH_AT    = 8'h40; // '@'
  localparam logic [7:0] CH_COLON = 8'h3A; // ':'
  localparam logic [7:0] CH_SPACE = 8'h20; // ' '
  localparam logic [7:0] CH_DOLL  = 8'h24; // '$'
  localparam logic [7:0] CH_STAR  = 8'h2A; // '*'
  localparam logic [7:0] CH_LT    = 8'h3C; // '<'
  localparam logic [7:0] CH_EQ    = 8'h3D; // '='
  localparam logic [7:0] CH_HASH  = 8'h23; // '#'

  // Decimal digit '0'..'9'
  function automatic logic is_dec(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Hex digit: '0'..'9' or lowercase 'a'..'f'; uppercase is not accepted
  function automatic logic is_hex(input logic [7:0] c);
    return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Nibble value of a hex digit; only meaningful when is_hex(c)
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return is_dec(c) ? c[3:0] : (c[3:0] + 4'd9);
  endfunction

endpackage

// File: rtl/cpu_record_extractor.sv
// Captures time / pc / destination / data fields from trace lines on the char bus
// and publishes them as one record when cpu_checker reports the line valid.
// Also keeps saturating counts of committed register-write and memory-write records.
module cpu_record_extractor
  import cpu_trace_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic [1:0]       format_type,
  output logic             rec_valid,
  output logic [1:0]       rec_type,
  output logic [13:0]      rec_time,
  output logic [31:0]      rec_pc,
  output logic [31:0]      rec_dst,
  output logic [31:0]      rec_data,
  output logic [CNT_W-1:0] reg_cnt,
  output logic [CNT_W-1:0] mem_cnt
);

  // FSM and shadow fields being assembled from the current line
  state_e      state_q, state_d;
  logic [13:0] time_q,  time_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] dst_q,   dst_d;
  logic [31:0] data_q,  data_d;

  // Published record and counters
  logic             rec_valid_q;
  logic [1:0]       rec_type_q;
  logic [13:0]      rec_time_q;
  logic [31:0]      rec_pc_q;
  logic [31:0]      rec_dst_q;
  logic [31:0]      rec_data_q;
  logic [CNT_W-1:0] reg_cnt_q;
  logic [CNT_W-1:0] mem_cnt_q;

  logic             commit;
  logic             ch_dec;
  logic             ch_hex;
  logic [3:0]       ch_nib;

  assign ch_dec = is_dec(char);
  assign ch_hex = is_hex(char);
  assign ch_nib = hex_val(char);

  // Only the two real verdicts publish; code 3 is treated like "none"
  assign commit = (format_type == FMT_REG) || (format_type == FMT_MEM);

  // State and shadow register update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      time_q  <= '0;
      pc_q    <= '0;
      dst_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      pc_q    <= pc_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
    end
  end

  // Next-state steering: each char either accumulates into the field of the
  // current state, advances to the next field, or abandons the line
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    pc_d    = pc_q;
    dst_d   = dst_q;
    data_d  = data_q;

    if (char == CH_CARET) begin
      // Start of a line from anywhere: restart with clean shadows
      state_d = S_TIME;
      time_d  = '0;
      pc_d    = '0;
      dst_d   = '0;
      data_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_TIME: begin
          if (ch_dec)              time_d  = (time_q * 14'd10) + {10'd0, char[3:0]};
          else if (char == CH_AT)  state_d = S_PC;
          else                     state_d = S_IDLE;
        end
        S_PC: begin
          if (ch_hex)                 pc_d    = {pc_q[27:0], ch_nib};
          else if (char == CH_COLON)  state_d = S_GAP;
          else                        state_d = S_IDLE;
        end
        S_GAP: begin
          if (char == CH_SPACE)      state_d = S_GAP;
          else if (char == CH_DOLL)  state_d = S_REG;
          else if (char == CH_STAR)  state_d = S_ADDR;
          else                       state_d = S_IDLE;
        end
        S_REG: begin
          if (ch_dec)                 dst_d   = (dst_q * 32'd10) + {28'd0, char[3:0]};
          else if (char == CH_SPACE)  state_d = S_REG;
          else if (char == CH_LT)     state_d = S_ARW;
          else                        state_d = S_IDLE;
        end
        S_ADDR: begin
          if (ch_hex)                 dst_d   = {dst_q[27:0], ch_nib};
          else if (char == CH_SPACE)  state_d = S_ADDR;
          else if (char == CH_LT)     state_d = S_ARW;
          else                        state_d = S_IDLE;
        end
        S_ARW: begin
          if (char == CH_EQ)  state_d = S_DATA;
          else                state_d = S_IDLE;
        end
        S_DATA: begin
          if (char == CH_SPACE)      state_d = S_DATA;
          else if (ch_hex)           data_d  = {data_q[27:0], ch_nib};
          else                       state_d = S_IDLE; // '#' ends the line, anything else aborts
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Record publication: shadows sampled before this edge, so a '^' arriving on
  // the commit edge clears the shadows without disturbing the record
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_valid_q <= 1'b0;
      rec_type_q  <= '0;
      rec_time_q  <= '0;
      rec_pc_q    <= '0;
      rec_dst_q   <= '0;
      rec_data_q  <= '0;
    end else begin
      rec_valid_q <= commit;
      if (commit) begin
        rec_type_q <= format_type;
        rec_time_q <= time_q;
        rec_pc_q   <= pc_q;
        rec_dst_q  <= dst_q;
        rec_data_q <= data_q;
      end
    end
  end

  // Saturating per-type record counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_cnt_q <= '0;
      mem_cnt_q <= '0;
    end else begin
      if ((format_type == FMT_REG) && (reg_cnt_q != {CNT_W{1'b1}}))
        reg_cnt_q <= reg_cnt_q + CNT_W'(1);
      if ((format_type == FMT_MEM) && (mem_cnt_q != {CNT_W{1'b1}}))
        mem_cnt_q <= mem_cnt_q + CNT_W'(1);
    end
  end

  assign rec_valid = rec_valid_q;
  assign rec_type  = rec_type_q;
  assign rec_time  = rec_time_q;
  assign rec_pc    = rec_pc_q;
  assign rec_dst   = rec_dst_q;
  assign rec_data  = rec_data_q;
  assign reg_cnt   = reg_cnt_q;
  assign mem_cnt   = mem_cnt_q;

endmodule

// File: tb/tb_cpu_record_extractor.sv
// Testbench for cpu_record_extractor: directed trace lines plus randomized lines,
// checked against a field-level record model. A second instance with 2-bit
// counters exercises counter saturation on the same traffic.
module tb_cpu_record_extractor;

  logic        clk;
  logic        reset;
  logic [7:0]  ch;
  logic [1:0]  ft;

  logic        rec_valid,   rec_valid_s;
  logic [1:0]  rec_type,    rec_type_s;
  logic [13:0] rec_time,    rec_time_s;
  logic [31:0] rec_pc,      rec_pc_s;
  logic [31:0] rec_dst,     rec_dst_s;
  logic [31:0] rec_data,    rec_data_s;
  logic [15:0] reg_cnt,     mem_cnt;
  logic [1:0]  reg_cnt_s,   mem_cnt_s;

  cpu_record_extractor #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .char(ch), .format_type(ft),
    .rec_valid(rec_valid), .rec_type(rec_type), .rec_time(rec_time),
    .rec_pc(rec_pc), .rec_dst(rec_dst), .rec_data(rec_data),
    .reg_cnt(reg_cnt), .mem_cnt(mem_cnt)
  );

  cpu_record_extractor #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .char(ch), .format_type(ft),
    .rec_valid(rec_valid_s), .rec_type(rec_type_s), .rec_time(rec_time_s),
    .rec_pc(rec_pc_s), .rec_dst(rec_dst_s), .rec_data(rec_data_s),
    .reg_cnt(reg_cnt_s), .mem_cnt(mem_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference record: what the published outputs should hold
  logic        exp_valid;
  logic [1:0]  exp_type;
  logic [31:0] exp_time, exp_pc, exp_dst, exp_data;
  int          exp_reg, exp_mem;
  // Fields of the line currently on the bus
  logic [31:0] p_time, p_pc, p_dst, p_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'd0, rec_valid}, {31'd0, exp_valid});
    chk({tag, ".type"},  {30'd0, rec_type}, {30'd0, exp_type});
    chk({tag, ".time"},  {18'd0, rec_time}, exp_time);
    chk({tag, ".pc"},    rec_pc, exp_pc);
    chk({tag, ".dst"},   rec_dst, exp_dst);
    chk({tag, ".data"},  rec_data, exp_data);
    chk({tag, ".reg_cnt"}, {16'd0, reg_cnt}, sat(exp_reg, 65535));
    chk({tag, ".mem_cnt"}, {16'd0, mem_cnt}, sat(exp_mem, 65535));
    chk({tag, ".reg_cnt2"}, {30'd0, reg_cnt_s}, sat(exp_reg, 3));
    chk({tag, ".mem_cnt2"}, {30'd0, mem_cnt_s}, sat(exp_mem, 3));
  endtask

  task automatic model_reset();
    exp_valid = 1'b0; exp_type = 2'd0;
    exp_time = 0; exp_pc = 0; exp_dst = 0; exp_data = 0;
    exp_reg = 0; exp_mem = 0;
  endtask

  // Present the characters of s from index 'from' onward, one per cycle
  task automatic send_str(input string s, input int from);
    for (int i = from; i < s.len(); i++) begin
      @(negedge clk);
      ch = s[i];
      ft = 2'd0;
    end
  endtask

  // Cycle after '#': checker verdict f is on the bus with char nxt.
  // Record is checked after the commit edge, and rec_valid low one cycle later.
  task automatic commit(input logic [1:0] f, input logic [7:0] nxt, input string tag);
    @(negedge clk);
    ch = nxt;
    ft = f;
    @(negedge clk);
    ft = 2'd0;
    if (f == 2'd1 || f == 2'd2) begin
      exp_valid = 1'b1;
      exp_type = f;
      exp_time = p_time; exp_pc = p_pc; exp_dst = p_dst; exp_data = p_data;
      if (f == 2'd1) exp_reg++; else exp_mem++;
    end else begin
      exp_valid = 1'b0;
    end
    check_all({tag, ".c"});
    @(negedge clk);
    exp_valid = 1'b0;
    check_all({tag, ".h"});
    $display("line %s: verdict=%0d type=%0d time=%0d pc=%h dst=%h data=%h reg=%0d mem=%0d",
             tag, f, rec_type, rec_time, rec_pc, rec_dst, rec_data, reg_cnt, mem_cnt);
  endtask

  // Build a random well-formed line and record its fields as the pending line
  function automatic string mk_line(input bit is_mem, input int t, input logic [31:0] pc,
                                    input logic [31:0] dst, input logic [31:0] d);
    string sp1, sp2, sp3, s;
    sp1 = ""; sp2 = ""; sp3 = "";
    repeat ($urandom_range(0, 2)) sp1 = {sp1, " "};
    repeat ($urandom_range(0, 2)) sp2 = {sp2, " "};
    repeat ($urandom_range(0, 2)) sp3 = {sp3, " "};
    s = {"^", $sformatf("%0d", t), "@", $sformatf("%h", pc), ":", sp1};
    if (is_mem) s = {s, "*", $sformatf("%h", dst)};
    else        s = {s, "$", $sformatf("%0d", dst)};
    s = {s, sp2, "<=", sp3, $sformatf("%h", d), "#"};
    return s;
  endfunction

  int st;
  int sat_seq [5] = '{1, 2, 3, 3, 3};

  initial begin
    reset = 1'b0; ch = 8'h00; ft = 2'd0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 1: register line
    p_time = 10; p_pc = 32'h3000; p_dst = 5; p_data = 32'habcd;
    send_str("^10@00003000: $5 <= 0000abcd#", 0);
    commit(2'd1, 8'h00, "t1");

    // 2: memory line, boundary time
    p_time = 9999; p_pc = 32'h300c; p_dst = 32'h1000; p_data = 32'hffffffff;
    send_str("^9999@0000300c: *00001000 <=  ffffffff#", 0);
    commit(2'd2, 8'h00, "t2");

    // 3: back-to-back reg then mem
    p_time = 7; p_pc = 32'h12345678; p_dst = 31; p_data = 32'h1;
    send_str("^7@12345678: $31 <= 1#", 0);
    commit(2'd1, 8'h5E, "t3a");
    p_time = 42; p_pc = 32'hdeadbeef; p_dst = 32'hc0; p_data = 32'h55;
    send_str("^42@deadbeef: *c0 <= 55#", 1);
    commit(2'd2, 8'h00, "t3b");

    // 4: checker rejects the line; then code 3 must also be ignored
    p_time = 12; p_pc = 32'h3000; p_dst = 1; p_data = 32'h1;
    send_str("^12@3000: $1 <= 1#", 0);
    commit(2'd0, 8'h00, "t4");
    send_str("^12@3000: $1 <= 1#", 0);
    commit(2'd3, 8'h00, "t4f3");

    // 5: asynchronous reset mid-line
    send_str("^10@00003000: $5", 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("t5rst");
    @(negedge clk);
    reset = 1'b1;
    p_time = 9999; p_pc = 32'h300c; p_dst = 32'h1000; p_data = 32'hffffffff;
    send_str("^9999@0000300c: *00001000 <=  ffffffff#", 0);
    commit(2'd2, 8'h00, "t5");

    // 6: counter saturation on the 2-bit instance
    for (int k = 0; k < 5; k++) begin
      p_time = $urandom_range(0, 9999); p_pc = $urandom; p_dst = $urandom_range(0, 31);
      p_data = $urandom;
      send_str(mk_line(1'b0, p_time, p_pc, p_dst, p_data), 0);
      commit(2'd1, 8'h00, $sformatf("t6_%0d", k));
      chk($sformatf("t6_sat%0d", k), {30'd0, reg_cnt_s}, sat_seq[k]);
    end

    // Randomized lines, verdicts and back-to-back spacing
    st = 0;
    for (int k = 0; k < 24; k++) begin
      bit          is_mem;
      logic [1:0]  f;
      logic [7:0]  nxt;
      int          r;
      is_mem = 1'($urandom_range(0, 1));
      p_time = $urandom_range(0, 9999);
      p_pc   = $urandom;
      p_dst  = is_mem ? $urandom : $urandom_range(0, 31);
      p_data = $urandom;
      r = $urandom_range(0, 5);
      if (r == 0)      f = 2'd0;
      else if (r == 1) f = 2'd3;
      else             f = is_mem ? 2'd2 : 2'd1;
      nxt = ($urandom_range(0, 1) == 1 && k < 23) ? 8'h5E : 8'h00;
      send_str(mk_line(is_mem, p_time, p_pc, p_dst, p_data), st);
      commit(f, nxt, $sformatf("r%0d", k));
      st = (nxt == 8'h5E) ? 1 : 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
